// File: rtl/fetch_stage_pkg.sv
// Shared constants and FSM state encoding for the MIPS fetch stage.
package fetch_stage_pkg;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        StReq   = 2'd0,
        StWait  = 2'd1,
        StReady = 2'd2,
        StDrop  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter register: async active-low reset to RESET_PC, load-enabled update.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, keeps one imem request in flight and presents the
// buffered instruction (or a NOP bubble) to the F/D pipeline register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        StallF,
    input  logic        PCSrcD,
    input  logic [31:0] pc_branch_D,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        fetch_valid_F,
    output logic [31:0] pc_F,
    output logic [31:0] pc_plus_four_F,
    output logic [31:0] instruction_F
);

    fetch_state_e state_q, state_d;
    logic         req_valid_q, req_valid_d;
    logic         fetch_valid_q, fetch_valid_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic         redirect, advance, pc_load;
    logic         unused_target_bits;

    assign redirect = PCSrcD & ~StallF;
    assign advance  = fetch_valid_q & ~StallF & ~PCSrcD;
    assign pc_load  = redirect | advance;
    assign pc_d     = redirect ? {pc_branch_D[31:2], 2'b00} : pc_plus_four_F;

    // Target is forced word-aligned; its low bits are intentionally dropped.
    assign unused_target_bits = ^pc_branch_D[1:0];

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (pc_load),
        .d       (pc_d),
        .q       (pc_q)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // req_valid_q gates acceptance so the first cycle after reset issues nothing.
            StReq: begin
                if (req_valid_q && imem_req_ready) begin
                    state_d = redirect ? StDrop : StWait;
                end
            end
            StWait: begin
                if (imem_resp_valid) begin
                    state_d = redirect ? StReq : StReady;
                end else if (redirect) begin
                    state_d = StDrop;
                end
            end
            StReady: begin
                if (redirect || advance) begin
                    state_d = StReq;
                end
            end
            StDrop: begin
                if (imem_resp_valid) begin
                    state_d = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    always_comb begin
        req_valid_d   = (state_d == StReq);
        fetch_valid_d = (state_d == StReady);
        instr_d       = NOP_INSTR;
        if (state_d == StReady) begin
            instr_d = (state_q == StWait) ? imem_resp_data : instr_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StReq;
            req_valid_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            instr_q       <= NOP_INSTR;
        end else begin
            state_q       <= state_d;
            req_valid_q   <= req_valid_d;
            fetch_valid_q <= fetch_valid_d;
            instr_q       <= instr_d;
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign pc_F           = pc_q;
    assign pc_plus_four_F = pc_q + 32'd4;
    assign fetch_valid_F  = fetch_valid_q;
    assign instruction_F  = instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized traffic, all checked
// against a flag-based model of request/response bookkeeping.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        StallF;
    logic        PCSrcD;
    logic [31:0] pc_branch_D;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fetch_valid_F;
    logic [31:0] pc_F;
    logic [31:0] pc_plus_four_F;
    logic [31:0] instruction_F;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: held instruction, outstanding request, staleness of that request.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic        m_out;
    logic        m_stale;
    logic        m_reqv;
    logic [31:0] acc_addr;
    int          mem_cnt;

    fetch_stage #(
        .RESET_PC(RESET_PC)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .StallF          (StallF),
        .PCSrcD          (PCSrcD),
        .pc_branch_D     (pc_branch_D),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fetch_valid_F   (fetch_valid_F),
        .pc_F            (pc_F),
        .pc_plus_four_F  (pc_plus_four_F),
        .instruction_F   (instruction_F)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memfunc(input logic [31:0] a);
        if (a == RESET_PC) return 32'h2008_0005;
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("req_valid", {31'd0, imem_req_valid}, {31'd0, m_reqv});
        check("imem_addr", imem_addr, m_pc);
        check("pc_F", pc_F, m_pc);
        check("pc_plus_four_F", pc_plus_four_F, m_pc + 32'd4);
        check("fetch_valid_F", {31'd0, fetch_valid_F}, {31'd0, m_valid});
        check("instruction_F", instruction_F, m_valid ? m_instr : NOP_INSTR);
    endtask

    task automatic model_reset();
        m_pc    = RESET_PC;
        m_valid = 1'b0;
        m_instr = NOP_INSTR;
        m_out   = 1'b0;
        m_stale = 1'b0;
        m_reqv  = 1'b0;
        mem_cnt = 0;
    endtask

    // Called at a negedge: check current outputs, drive inputs, advance one clock.
    task automatic step(input logic st, input logic ps, input logic [31:0] tgt,
                        input logic rdy, input logic rv);
        logic        redirect;
        logic        adv;
        logic [31:0] data;
        check_all();
        data            = m_out ? memfunc(acc_addr) : $urandom();
        StallF          = st;
        PCSrcD          = ps;
        pc_branch_D     = tgt;
        imem_req_ready  = rdy;
        imem_resp_valid = rv;
        imem_resp_data  = data;
        @(posedge clock);
        redirect = ps & ~st;
        adv      = m_valid & ~st & ~ps;
        if (m_out) begin
            if (rv) begin
                m_out = 1'b0;
                if (!m_stale && !redirect) begin
                    m_valid = 1'b1;
                    m_instr = data;
                end
            end else begin
                if (redirect) m_stale = 1'b1;
                mem_cnt--;
            end
        end else if (m_valid) begin
            if (redirect || adv) m_valid = 1'b0;
        end else if (m_reqv && rdy) begin
            m_out    = 1'b1;
            m_stale  = redirect;
            acc_addr = m_pc;
            mem_cnt  = $urandom_range(1, 4);
        end
        if (redirect) m_pc = {tgt[31:2], 2'b00};
        else if (adv) m_pc = m_pc + 32'd4;
        m_reqv = !m_out && !m_valid;
        @(negedge clock);
    endtask

    initial begin
        logic        st, ps, rdy, rv;
        logic [31:0] tgt;

        reset_n         = 1'b0;
        StallF          = 1'b0;
        PCSrcD          = 1'b0;
        pc_branch_D     = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("reset_pc", pc_F, RESET_PC);
        check("reset_pc4", pc_plus_four_F, RESET_PC + 32'd4);
        check("reset_instr", instruction_F, NOP_INSTR);
        reset_n = 1'b1;

        // Reset release and first fetch
        step(0, 0, 0, 1, 0);
        check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("first_addr", imem_addr, 32'h0040_0000);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        check("first_fetch_valid", {31'd0, fetch_valid_F}, 32'd1);
        check("first_instr", instruction_F, 32'h2008_0005);
        check("first_pc4", pc_plus_four_F, 32'h0040_0004);

        // Stall hold in READY
        repeat (4) step(1, 0, 0, 0, 0);
        check("stall_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("stall_instr", instruction_F, 32'h2008_0005);
        step(0, 0, 0, 0, 0);
        check("advance_pc", pc_F, 32'h0040_0004);
        check("advance_req_valid", {31'd0, imem_req_valid}, 32'd1);

        // Redirect in WAIT, then the stale response
        step(0, 0, 0, 1, 0);
        step(0, 1, 32'h0040_0103, 0, 0);
        check("drop_pc", pc_F, 32'h0040_0100);
        check("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
        step(0, 0, 0, 0, 1);
        check("stale_fetch_valid", {31'd0, fetch_valid_F}, 32'd0);
        check("stale_then_addr", imem_addr, 32'h0040_0100);
        check("stale_then_req", {31'd0, imem_req_valid}, 32'd1);

        // Redirect coinciding with the response
        step(0, 0, 0, 1, 0);
        step(0, 1, 32'h0040_0200, 0, 1);
        check("simul_addr", imem_addr, 32'h0040_0200);
        check("simul_fetch_valid", {31'd0, fetch_valid_F}, 32'd0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        check("simul_refetch", instruction_F, memfunc(32'h0040_0200));

        // Redirect while stalled is ignored, then taken
        step(1, 1, 32'h0040_0300, 0, 0);
        check("stalled_redirect_pc", pc_F, 32'h0040_0200);
        step(0, 1, 32'h0040_0300, 0, 0);
        check("released_redirect_pc", pc_F, 32'h0040_0300);
        check("released_fetch_valid", {31'd0, fetch_valid_F}, 32'd0);

        // PC wrap
        step(0, 1, 32'hFFFF_FFFE, 0, 0);
        check("wrap_pc4", pc_plus_four_F, 32'h0000_0000);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        check("wrap_pc", pc_F, 32'h0000_0000);

        // Backpressure, then async reset mid-WAIT
        repeat (5) step(0, 0, 0, 0, 0);
        check("bp_addr", imem_addr, 32'h0000_0000);
        step(0, 0, 0, 1, 0);
        #2 reset_n = 1'b0;
        #1;
        check("areset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("areset_pc", pc_F, RESET_PC);
        check("areset_fetch_valid", {31'd0, fetch_valid_F}, 32'd0);
        check("areset_instr", instruction_F, NOP_INSTR);
        model_reset();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            ps  = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            tgt = $urandom();
            if ($urandom_range(0, 7) == 0) tgt[31:2] = 30'h3FFF_FFFF;
            else tgt = RESET_PC + $urandom_range(0, 4095);
            if (m_out) rv = (mem_cnt <= 1);
            else rv = ($urandom_range(0, 15) == 0);
            step(st, ps, tgt, rdy, rv);
        end
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
